// File: rtl/vfxp_pkg.sv
// Shared types and helpers for the vector fixed-point rounding-shift datapath.
package vfxp_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned SHAMT_W = $clog2(DATA_W);
    localparam int unsigned SEWB_W  = SHAMT_W + 1;

    typedef enum logic [1:0] {
        VXRM_RNU = 2'b00,
        VXRM_RNE = 2'b01,
        VXRM_RDN = 2'b10,
        VXRM_ROD = 2'b11
    } vxrm_e;

    typedef enum logic [1:0] {
        SEW_8      = 2'b00,
        SEW_16     = 2'b01,
        SEW_32     = 2'b10,
        SEW_32_ALT = 2'b11
    } sew_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    typedef struct packed {
        logic [IDX_W:0]     vl;
        sew_e               sew;
        vxrm_e              vxrm;
        logic               sgn;
        logic [SHAMT_W-1:0] shamt;
    } cmd_t;

    // Element width in bits; the reserved encoding behaves as 32.
    function automatic logic [SEWB_W-1:0] sew_bits(sew_e sew);
        logic [SEWB_W-1:0] bits;
        case (sew)
            SEW_8:   bits = SEWB_W'(8);
            SEW_16:  bits = SEWB_W'(16);
            default: bits = SEWB_W'(32);
        endcase
        return bits;
    endfunction

    // Truncate to SEW and re-extend to the full datapath width.
    function automatic logic [DATA_W-1:0] extend_sew(logic [DATA_W-1:0] x, sew_e sew, logic sgn);
        logic [DATA_W-1:0] y;
        case (sew)
            SEW_8:   y = {{(DATA_W-8){sgn & x[7]}}, x[7:0]};
            SEW_16:  y = {{(DATA_W-16){sgn & x[15]}}, x[15:0]};
            default: y = x;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/vfxp_round_shift.sv
// Combinational rounding right shift of one element under vxrm, for any SEW.
module vfxp_round_shift
    import vfxp_pkg::*;
(
    input  logic [DATA_W-1:0]  v_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  vxrm_e              vxrm_i,
    input  sew_e               sew_i,
    input  logic               sgn_i,
    output logic [DATA_W-1:0]  res_c
);

    logic [SHAMT_W-1:0]       d;
    logic [DATA_W-1:0]        ext;
    logic signed [DATA_W-1:0] sra;
    logic [DATA_W-1:0]        srl;
    logic [DATA_W-1:0]        shifted;
    logic [DATA_W-1:0]        low_mask;
    logic                     half;
    logic                     sticky;
    logic                     lsb;
    logic                     rinc;

    // Shift the SEW-extended element and add the rounding increment from the discarded bits.
    always_comb begin
        half     = 1'b0;
        sticky   = 1'b0;
        rinc     = 1'b0;
        d        = shamt_i & SHAMT_W'(sew_bits(sew_i) - SEWB_W'(1));
        ext      = extend_sew(v_i, sew_i, sgn_i);
        sra      = $signed(ext) >>> d;
        srl      = ext >> d;
        shifted  = sgn_i ? unsigned'(sra) : srl;
        low_mask = (DATA_W'(1) << d) - DATA_W'(1);
        lsb      = ext[d];
        if (d != '0) begin
            half   = ext[d - SHAMT_W'(1)];
            sticky = |(ext & (low_mask >> 1));
            case (vxrm_i)
                VXRM_RNU: rinc = half;
                VXRM_RNE: rinc = half & (sticky | lsb);
                VXRM_RDN: rinc = 1'b0;
                default:  rinc = ~lsb & (|(ext & low_mask));
            endcase
        end
        res_c = extend_sew(shifted + DATA_W'(rinc), sew_i, sgn_i);
    end

endmodule

// File: rtl/vfxp_shift_sequencer.sv
// Walks vstart..vl-1 of one vssra/vssrl command and streams rounded results to writeback.
module vfxp_shift_sequencer
    import vfxp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IDX_W:0]    cmd_vl,
    input  logic [IDX_W-1:0]  cmd_vstart,
    input  logic [1:0]        cmd_sew,
    input  logic [1:0]        cmd_vxrm,
    input  logic              cmd_signed,
    input  logic [DATA_W-1:0] cmd_shamt,
    input  logic              flush,
    output logic [IDX_W-1:0]  src_idx,
    output logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [IDX_W-1:0]  wb_idx,
    output logic [DATA_W-1:0] wb_data,
    output logic              done,
    output logic              busy
);

    state_e             state_q, state_d;
    cmd_t               cmd_q, cmd_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wb_valid_q, wb_valid_d;
    logic [IDX_W-1:0]   wb_idx_q, wb_idx_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;
    logic               done_q, done_d;
    logic               advance_c;
    logic               last_c;
    logic [DATA_W-1:0]  res_c;
    logic               unused_shamt_hi;

    // Only log2(SEW) shift bits matter; the upper bits are architecturally ignored.
    assign unused_shamt_hi = ^cmd_shamt[DATA_W-1:SHAMT_W];

    vfxp_round_shift u_round_shift (
        .v_i     (src_data),
        .shamt_i (cmd_q.shamt),
        .vxrm_i  (cmd_q.vxrm),
        .sew_i   (cmd_q.sew),
        .sgn_i   (cmd_q.sgn),
        .res_c   (res_c)
    );

    // Next-state, index counter and result-register control.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        idx_d      = idx_q;
        wb_valid_d = wb_valid_q;
        wb_idx_d   = wb_idx_q;
        wb_data_d  = wb_data_q;
        done_d     = 1'b0;
        advance_c  = (state_q == ST_RUN) && (!wb_valid_q || wb_ready);
        last_c     = ({1'b0, idx_q} + (IDX_W+1)'(1)) == cmd_q.vl;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d.vl    = cmd_vl;
                    cmd_d.sew   = sew_e'(cmd_sew);
                    cmd_d.vxrm  = vxrm_e'(cmd_vxrm);
                    cmd_d.sgn   = cmd_signed;
                    cmd_d.shamt = cmd_shamt[SHAMT_W-1:0];
                    idx_d       = cmd_vstart;
                    if ({1'b0, cmd_vstart} >= cmd_vl) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (advance_c) begin
                    wb_valid_d = 1'b1;
                    wb_idx_d   = idx_q;
                    wb_data_d  = res_c;
                    idx_d      = idx_q + IDX_W'(1);
                    if (last_c) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (wb_valid_q && wb_ready) begin
                    wb_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d    = ST_IDLE;
            wb_valid_d = 1'b0;
            done_d     = 1'b0;
        end
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            idx_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_idx_q   <= '0;
            wb_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            idx_q      <= idx_d;
            wb_valid_q <= wb_valid_d;
            wb_idx_q   <= wb_idx_d;
            wb_data_q  <= wb_data_d;
            done_q     <= done_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign src_idx   = idx_q;
    assign src_valid = advance_c;
    assign wb_valid  = wb_valid_q;
    assign wb_idx    = wb_idx_q;
    assign wb_data   = wb_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vfxp_shift_sequencer.sv
// Randomized and directed checks of vfxp_shift_sequencer against an arithmetic reference model.
module tb_vfxp_shift_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned IW = 5;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          cmd_valid  = 1'b0;
    logic          cmd_ready;
    logic [IW:0]   cmd_vl     = '0;
    logic [IW-1:0] cmd_vstart = '0;
    logic [1:0]    cmd_sew    = '0;
    logic [1:0]    cmd_vxrm   = '0;
    logic          cmd_signed = 1'b0;
    logic [DW-1:0] cmd_shamt  = '0;
    logic          flush      = 1'b0;
    logic [IW-1:0] src_idx;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          wb_valid;
    logic          wb_ready   = 1'b1;
    logic [IW-1:0] wb_idx;
    logic [DW-1:0] wb_data;
    logic          done;
    logic          busy;

    logic [DW-1:0] mem [32];
    assign src_data = mem[src_idx];

    vfxp_shift_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_vl     (cmd_vl),
        .cmd_vstart (cmd_vstart),
        .cmd_sew    (cmd_sew),
        .cmd_vxrm   (cmd_vxrm),
        .cmd_signed (cmd_signed),
        .cmd_shamt  (cmd_shamt),
        .flush      (flush),
        .src_idx    (src_idx),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_idx     (wb_idx),
        .wb_data    (wb_data),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            passed = 0;
    int            total  = 0;
    int            got_idx [$];
    logic [DW-1:0] got_data [$];
    int            got_cyc [$];
    int            done_cyc [$];
    int            bad_reads;
    int            unstable;
    int            stall_cycles;
    int            acc_cyc;
    bit            timed_out;

    // Observe writeback handshakes, done pulses and reads issued while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_valid && wb_ready) begin
                got_idx.push_back(int'(wb_idx));
                got_data.push_back(wb_data);
                got_cyc.push_back(cyc);
            end
            if (done) done_cyc.push_back(cyc);
            if (src_valid && wb_valid && !wb_ready) bad_reads++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Reference: floor-shift with remainder-based rounding, wrap modulo 2^SEW, re-extend.
    function automatic logic [31:0] model(input logic [31:0] x, input int sew, input int rm,
                                          input bit sg, input logic [31:0] shamt);
        int     bits;
        int     d;
        int     r;
        longint m, v, p, sh, rem, half, res;
        bits = (sew == 0) ? 8 : (sew == 1) ? 16 : 32;
        m    = longint'(1) << bits;
        v    = longint'({32'b0, x}) & (m - 1);
        if (sg && v >= m / 2) v = v - m;
        d    = int'(shamt % 32'(bits));
        p    = longint'(1) << d;
        if (v >= 0) sh = v / p;
        else        sh = -((-v + p - 1) / p);
        rem  = v - sh * p;
        half = p / 2;
        r    = 0;
        if (d != 0) begin
            case (rm)
                0:       r = int'(rem >= half);
                1:       r = int'((rem > half) || (rem == half && (sh % 2 != 0)));
                2:       r = 0;
                default: r = int'((rem != 0) && (sh % 2 == 0));
            endcase
        end
        res = (sh + longint'(r)) % m;
        if (res < 0) res = res + m;
        if (sg && res >= m / 2) res = res - m;
        return res[31:0];
    endfunction

    task automatic clear_obs();
        got_idx.delete();
        got_data.delete();
        got_cyc.delete();
        done_cyc.delete();
        bad_reads    = 0;
        unstable     = 0;
        stall_cycles = 0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 32; i++) mem[i] = $urandom | 32'h1;
    endtask

    // Issue one command and wait (bounded) for done. md: 0 ready high, 1 random ready, 2 stall on idx 1.
    task automatic run_cmd(input int vl, input int vs, input int sew, input int rm, input bit sg,
                           input logic [31:0] shamt, input int md, input bit now, input int budget);
        int            n;
        bit            seen;
        int            stall_left;
        bit            stalled;
        logic [IW-1:0] snap_idx;
        logic [DW-1:0] snap_data;
        if (!now) begin
            @(posedge clk);
            #1;
        end
        cmd_vl     = (IW+1)'(vl);
        cmd_vstart = IW'(vs);
        cmd_sew    = 2'(sew);
        cmd_vxrm   = 2'(rm);
        cmd_signed = sg;
        cmd_shamt  = shamt;
        cmd_valid  = 1'b1;
        acc_cyc    = cyc;
        wb_ready   = (md == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        n          = 0;
        seen       = 1'b0;
        stall_left = 0;
        stalled    = 1'b0;
        snap_idx   = '0;
        snap_data  = '0;
        while (!seen && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            cmd_valid = 1'b0;
            if (done) seen = 1'b1;
            case (md)
                1: wb_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (!stalled && wb_valid && wb_idx == IW'(1)) begin
                        stalled    = 1'b1;
                        stall_left = 3;
                        snap_idx   = wb_idx;
                        snap_data  = wb_data;
                    end
                    if (stall_left > 0) begin
                        stall_left--;
                        stall_cycles++;
                        wb_ready = 1'b0;
                        if (wb_idx !== snap_idx || wb_data !== snap_data || wb_valid !== 1'b1) unstable++;
                    end else begin
                        wb_ready = 1'b1;
                    end
                end
                default: wb_ready = 1'b1;
            endcase
        end
        timed_out = !seen;
        wb_ready  = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset cmd_ready: got %b expected 1", cmd_ready); else passed++;
        total++; if (src_valid !== 1'b0) $display("FAIL reset src_valid: got %b expected 0", src_valid); else passed++;
        total++; if (wb_valid !== 1'b0) $display("FAIL reset wb_valid: got %b expected 0", wb_valid); else passed++;
        total++; if (wb_idx !== '0) $display("FAIL reset wb_idx: got %0d expected 0", wb_idx); else passed++;
        total++; if (wb_data !== '0) $display("FAIL reset wb_data: got %h expected 0", wb_data); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset done: got %b expected 0", done); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy); else passed++;
    endtask

    typedef struct {
        int          sew;
        int          rm;
        bit          sg;
        logic [31:0] shamt;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    task automatic test_directed();
        vec_t        vecs [9];
        logic [31:0] got;
        vecs[0] = '{0, 0, 1'b1, 32'd1,  32'h123456F9, 32'hFFFFFFFD};
        vecs[1] = '{0, 0, 1'b1, 32'd2,  32'h00000007, 32'h00000002};
        vecs[2] = '{0, 1, 1'b0, 32'd2,  32'h00000006, 32'h00000002};
        vecs[3] = '{0, 1, 1'b0, 32'd2,  32'h0000000A, 32'h00000002};
        vecs[4] = '{0, 3, 1'b0, 32'd2,  32'h00000005, 32'h00000001};
        vecs[5] = '{0, 3, 1'b0, 32'd2,  32'h00000009, 32'h00000003};
        vecs[6] = '{0, 2, 1'b0, 32'd2,  32'h00000007, 32'h00000001};
        vecs[7] = '{2, 0, 1'b1, 32'h25, 32'h80000010, 32'hFC000001};
        vecs[8] = '{1, 0, 1'b0, 32'h13, 32'hFFFF8001, 32'h00001000};
        for (int i = 0; i < 9; i++) begin
            clear_obs();
            mem[0] = vecs[i].din;
            run_cmd(1, 0, vecs[i].sew, vecs[i].rm, vecs[i].sg, vecs[i].shamt, 0, 1'b0, 20);
            got = (got_data.size() > 0) ? got_data[0] : 32'hxxxxxxxx;
            total++;
            if (got !== vecs[i].exp) $display("FAIL directed[%0d] wb_data: got %h expected %h", i, got, vecs[i].exp);
            else passed++;
        end
    endtask

    task automatic test_throughput();
        int nw;
        clear_obs();
        fill_mem();
        run_cmd(4, 0, 2, 0, 1'b0, 32'd0, 0, 1'b0, 20);
        nw = got_idx.size();
        total++; if (nw != 4) $display("FAIL thru count: got %0d expected 4", nw); else passed++;
        for (int i = 0; i < 4 && i < nw; i++) begin
            total++;
            if (got_idx[i] != i || got_cyc[i] - acc_cyc != 2 + i || got_data[i] !== mem[i])
                $display("FAIL thru elem %0d: got idx %0d cyc %0d data %h expected idx %0d cyc %0d data %h",
                         i, got_idx[i], got_cyc[i] - acc_cyc, got_data[i], i, 2 + i, mem[i]);
            else passed++;
        end
        total++;
        if (done_cyc.size() != 1 || done_cyc[0] - acc_cyc != 6)
            $display("FAIL thru done: got %0d pulses first at %0d expected 1 pulse at 6",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - acc_cyc : -1);
        else passed++;
    endtask

    task automatic test_empty();
        clear_obs();
        run_cmd(4, 4, 0, 0, 1'b0, 32'd0, 0, 1'b0, 10);
        total++;
        if (done_cyc.size() != 1 || done_cyc[0] - acc_cyc != 1)
            $display("FAIL empty done: got %0d pulses first at %0d expected 1 pulse at 1",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - acc_cyc : -1);
        else passed++;
        total++; if (got_idx.size() != 0) $display("FAIL empty writes: got %0d expected 0", got_idx.size()); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL empty busy: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_stall();
        logic [31:0] shamt;
        shamt = 32'd3;
        clear_obs();
        fill_mem();
        run_cmd(3, 0, 1, 1, 1'b1, shamt, 2, 1'b0, 30);
        total++; if (timed_out) $display("FAIL stall timeout: got no done expected done"); else passed++;
        total++; if (got_idx.size() != 3) $display("FAIL stall count: got %0d expected 3", got_idx.size()); else passed++;
        for (int i = 0; i < 3 && i < got_idx.size(); i++) begin
            total++;
            if (got_idx[i] != i || got_data[i] !== model(mem[i], 1, 1, 1'b1, shamt))
                $display("FAIL stall elem %0d: got idx %0d data %h expected idx %0d data %h",
                         i, got_idx[i], got_data[i], i, model(mem[i], 1, 1, 1'b1, shamt));
            else passed++;
        end
        total++; if (stall_cycles != 3) $display("FAIL stall cycles: got %0d expected 3", stall_cycles); else passed++;
        total++; if (unstable != 0) $display("FAIL stall stability: got %0d changes expected 0", unstable); else passed++;
        total++; if (bad_reads != 0) $display("FAIL stall reads: got %0d expected 0", bad_reads); else passed++;
        total++;
        if (done_cyc.size() != 1 || done_cyc[0] - acc_cyc != 8)
            $display("FAIL stall done: got %0d pulses first at %0d expected 1 pulse at 8",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - acc_cyc : -1);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int          a_rel;
        int          dcyc;
        int          exp_idx [4];
        logic [31:0] exp_dat [4];
        logic [31:0] shamt_b;
        shamt_b = 32'h0000_0101;
        clear_obs();
        fill_mem();
        run_cmd(2, 0, 2, 0, 1'b0, 32'd0, 0, 1'b0, 20);
        a_rel = (done_cyc.size() > 0) ? done_cyc[0] - acc_cyc : -1;
        total++; if (a_rel != 4) $display("FAIL b2b first done: got %0d expected 4", a_rel); else passed++;
        total++;
        if (done !== 1'b1 || cmd_ready !== 1'b1)
            $display("FAIL b2b done/cmd_ready: got %b/%b expected 1/1", done, cmd_ready);
        else passed++;
        dcyc = cyc;
        run_cmd(3, 1, 0, 3, 1'b1, shamt_b, 0, 1'b1, 20);
        exp_idx = '{0, 1, 1, 2};
        exp_dat[0] = mem[0];
        exp_dat[1] = mem[1];
        exp_dat[2] = model(mem[1], 0, 3, 1'b1, shamt_b);
        exp_dat[3] = model(mem[2], 0, 3, 1'b1, shamt_b);
        total++; if (got_idx.size() != 4) $display("FAIL b2b count: got %0d expected 4", got_idx.size()); else passed++;
        for (int i = 0; i < 4 && i < got_idx.size(); i++) begin
            total++;
            if (got_idx[i] != exp_idx[i] || got_data[i] !== exp_dat[i])
                $display("FAIL b2b elem %0d: got idx %0d data %h expected idx %0d data %h",
                         i, got_idx[i], got_data[i], exp_idx[i], exp_dat[i]);
            else passed++;
        end
        total++;
        if (done_cyc.size() != 2 || done_cyc[done_cyc.size() - 1] - dcyc != 4)
            $display("FAIL b2b second done: got %0d pulses last at %0d expected 2 pulses last at 4",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[done_cyc.size() - 1] - dcyc : -1);
        else passed++;
    endtask

    task automatic test_flush();
        logic [31:0] shamt_b;
        shamt_b = $urandom;
        clear_obs();
        fill_mem();
        @(posedge clk);
        #1;
        cmd_vl     = 7'(8);
        cmd_vstart = '0;
        cmd_sew    = 2'd2;
        cmd_vxrm   = 2'd0;
        cmd_signed = 1'b0;
        cmd_shamt  = '0;
        cmd_valid  = 1'b1;
        wb_ready   = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL flush busy: got %b expected 0", busy); else passed++;
        total++; if (wb_valid !== 1'b0) $display("FAIL flush wb_valid: got %b expected 0", wb_valid); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL flush cmd_ready: got %b expected 1", cmd_ready); else passed++;
        @(negedge clk);
        #1;
        total++; if (done_cyc.size() != 0) $display("FAIL flush done: got %0d pulses expected 0", done_cyc.size()); else passed++;
        clear_obs();
        run_cmd(7, 5, 0, 1, 1'b1, shamt_b, 0, 1'b1, 20);
        total++; if (got_idx.size() != 2) $display("FAIL flush next count: got %0d expected 2", got_idx.size()); else passed++;
        for (int i = 0; i < 2 && i < got_idx.size(); i++) begin
            total++;
            if (got_idx[i] != 5 + i || got_data[i] !== model(mem[5 + i], 0, 1, 1'b1, shamt_b))
                $display("FAIL flush next elem %0d: got idx %0d data %h expected idx %0d data %h",
                         i, got_idx[i], got_data[i], 5 + i, model(mem[5 + i], 0, 1, 1'b1, shamt_b));
            else passed++;
        end
        total++;
        if (done_cyc.size() != 1 || done_cyc[0] - acc_cyc != 4)
            $display("FAIL flush next done: got %0d pulses first at %0d expected 1 pulse at 4",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - acc_cyc : -1);
        else passed++;
    endtask

    task automatic test_random();
        int          vl, vs, sew, rm, n;
        bit          sg;
        logic [31:0] shamt, exp;
        for (int t = 0; t < 8; t++) begin
            vl    = $urandom_range(1, 32);
            vs    = $urandom_range(0, vl - 1);
            sew   = $urandom_range(0, 3);
            rm    = $urandom_range(0, 3);
            sg    = 1'($urandom_range(0, 1));
            shamt = $urandom;
            n     = vl - vs;
            clear_obs();
            fill_mem();
            run_cmd(vl, vs, sew, rm, sg, shamt, 1, 1'b0, 400);
            total++; if (timed_out) $display("FAIL rand[%0d] timeout: got no done expected done", t); else passed++;
            total++;
            if (got_idx.size() != n) $display("FAIL rand[%0d] count: got %0d expected %0d", t, got_idx.size(), n);
            else passed++;
            for (int i = 0; i < n && i < got_idx.size(); i++) begin
                exp = model(mem[vs + i], sew, rm, sg, shamt);
                total++;
                if (got_idx[i] != vs + i || got_data[i] !== exp)
                    $display("FAIL rand[%0d] elem %0d: got idx %0d data %h expected idx %0d data %h",
                             t, i, got_idx[i], got_data[i], vs + i, exp);
                else passed++;
            end
            total++; if (bad_reads != 0) $display("FAIL rand[%0d] stalled reads: got %0d expected 0", t, bad_reads); else passed++;
            total++; if (done_cyc.size() != 1) $display("FAIL rand[%0d] done pulses: got %0d expected 1", t, done_cyc.size()); else passed++;
        end
    endtask

    task automatic test_rst_mid_run();
        clear_obs();
        fill_mem();
        @(posedge clk);
        #1;
        cmd_vl     = 7'(8);
        cmd_vstart = '0;
        cmd_sew    = 2'd2;
        cmd_vxrm   = 2'd2;
        cmd_signed = 1'b0;
        cmd_shamt  = '0;
        cmd_valid  = 1'b1;
        wb_ready   = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b1) $display("FAIL rst cmd_ready: got %b expected 1", cmd_ready); else passed++;
        total++; if (src_valid !== 1'b0) $display("FAIL rst src_valid: got %b expected 0", src_valid); else passed++;
        total++; if (wb_valid !== 1'b0) $display("FAIL rst wb_valid: got %b expected 0", wb_valid); else passed++;
        total++; if (wb_idx !== '0) $display("FAIL rst wb_idx: got %0d expected 0", wb_idx); else passed++;
        total++; if (wb_data !== '0) $display("FAIL rst wb_data: got %h expected 0", wb_data); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rst done: got %b expected 0", done); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst busy: got %b expected 0", busy); else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_obs();
        run_cmd(2, 0, 2, 0, 1'b0, 32'd0, 0, 1'b0, 20);
        total++;
        if (got_idx.size() != 2 || done_cyc.size() != 1)
            $display("FAIL rst recovery: got %0d writes %0d done expected 2 writes 1 done", got_idx.size(), done_cyc.size());
        else passed++;
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_directed();
        test_throughput();
        test_empty();
        test_stall();
        test_back_to_back();
        test_flush();
        test_random();
        test_rst_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vfxp_shift_sequencer.md
# vfxp_shift_sequencer

Element sequencer for the vector fixed-point rounding-shift datapath (vssra/vssrl). It accepts one vector command, walks element indices vstart..vl-1, reads each source element and computes the vxrm rounding increment. It drives one registered rounding-shift stage and streams results to the vector writeback port under valid/ready backpressure. It sits between vector issue and the vector register file write port and is the sole owner of the fixed-point shift datapath.

## Interface
- DATA_W, 32, element datapath width (max SEW)
- IDX_W, 5, element index width (max VL = 2^IDX_W)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_vl  in  IDX_W+1  element count
- cmd_vstart  in  IDX_W  first element
- cmd_sew  in  2  00=8, 01=16, 10=32 (11 treated as 32)
- cmd_vxrm  in  2  00 rnu, 01 rne, 10 rdn, 11 rod
- cmd_signed  in  1  1 = arithmetic shift (vssra), 0 = logical (vssrl)
- cmd_shamt  in  DATA_W  shift amount; only low log2(SEW) bits used
- flush  in  1  abort current command
- src_idx  out  IDX_W  element read index
- src_valid  out  1  read request this cycle
- src_data  in  DATA_W  element data, combinational from src_idx
- wb_valid  out  1  result valid
- wb_ready  in  1  writeback accepts
- wb_idx  out  IDX_W  result element index
- wb_data  out  DATA_W  result, sign- or zero-extended from SEW
- done  out  1  one-cycle pulse at command completion
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid, latch all cmd fields and set idx=cmd_vstart.
  - If cmd_vstart >= cmd_vl: pulse done next cycle and stay IDLE. No writes occur.
  - Otherwise go to RUN.
- RUN: src_valid=1 when the result register is empty or wb_ready=1 (advance). On advance, the result register loads {idx, rounded result} and idx increments. After issuing element vl-1, go to DRAIN.
- DRAIN: hold until the result register is accepted (wb_valid && wb_ready), then pulse done and go to IDLE.
- Element arithmetic:
  - v = src_data truncated to SEW bits and extended per cmd_signed.
  - d = shamt mod SEW.
  - shifted = v >> d (arithmetic if signed).
  - r by vxrm:
    - rnu: v[d-1]
    - rne: v[d-1] & (v[d-2:0]!=0 | v[d])
    - rdn: 0
    - rod: !v[d] & (v[d-1:0]!=0)
  - r=0 whenever d=0. Terms with a negative index read as 0.
  - result = shifted + r, wrapped to SEW bits, then extended to DATA_W (sign if signed, else zero).
- flush: dominates all other inputs. Next cycle state=IDLE, wb_valid=0, no done pulse, and any in-flight result is dropped.
- cmd_valid while busy is ignored, since cmd_ready=0.

## Timing
- Reset values:
  - state=IDLE, cmd_ready=1, src_valid=0
  - wb_valid=0, wb_idx=0, wb_data=0
  - done=0, busy=0
- Accept at cycle 0, first src_valid at cycle 1, first wb_valid at cycle 2.
- Throughput is 1 element/cycle with wb_ready held high. N elements give done at cycle N+2.
- With wb_ready=0, wb_valid, wb_idx and wb_data hold stable, and src_valid drops (no read issued).
- done and cmd_ready=1 coincide in the same cycle. A new command may be accepted that cycle.
- Asserting rst mid-command returns all outputs to reset values immediately.

## Structure
- Shared package vfxp_pkg holds:
  - vxrm encodings (RNU/RNE/RDN/ROD)
  - SEW encodings
  - state enum
  - sew-to-bits function
- Sub-module vfxp_round_shift is a combinational {v, d, vxrm, sew, signed} -> result unit. It is reusable by the narrowing-clip path.
- The sequencer holds the FSM, index counter and result register.

## Test plan
- sew=8, rnu, signed, shamt=1, element 0xF9 -> wb_data=0xFFFFFFFD (-3). sew=8, rnu, shamt=2, element 0x07 -> 0x02.
- sew=8, rne, unsigned, shamt=2, elements 0x06, 0x0A -> 0x02, 0x02. rod on 0x05, 0x09 -> 0x01, 0x03. rdn on 0x07 -> 0x01.
- vl=4, vstart=0, wb_ready=1 -> wb_idx 0,1,2,3 on cycles 2-5, done at cycle 6. vstart=4, vl=4 -> done at cycle 1, no wb_valid.
- vl=3 with wb_ready low for 3 cycles on idx 1 -> wb_data/wb_idx stable, no src read issued, done after idx 2 accepted, no duplicates.
- flush at cycle 3 of vl=8 -> IDLE next cycle, wb_valid=0, no done. A new command is accepted next cycle and starts at its own vstart.
- sew=32, shamt=0x25 (d=5), rnu, signed, 0x80000010 -> 0xFC000001 (shifted 0xFC000000, r=v[4]=1). rst asserted mid-RUN -> reset values.
